// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding and the round-robin pointer wrap.
// No logic of its own; imported by uart_tx_arbiter and rr_pick.
package uart_arb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        START,
        ARM,
        BUSY,
        DONE
    } state_t;

    // Pointer position just after ptr, wrapping from nreq-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
        return (ptr + 32'd1 >= nreq) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit scanning upward from ptr with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; valid simply reflects whether any request is set.
// Ports: req (request vector), ptr (highest-priority index),
//        valid (any request set), idx (chosen requester).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int pos;

    // Walk the offsets from farthest to nearest so the nearest set bit
    // (lowest offset from ptr) is the one left in idx.
    always_comb begin
        valid = |req;
        idx   = '0;
        pos   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (req[IW'(pos)]) begin
                idx = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte serializer among NREQ requesters.
// Latency: req seen in IDLE -> ser_start two cycles later; ack one cycle after ser_busy falls.
// Backpressure: requesters hold req until ack; no grant while the serializer reports busy.
// Ports: clk, reset (sync, active-high); req/req_data from clients; ack, grant_idx, busy status;
//        ser_start/ser_data to the serializer, ser_busy from it; err on timeout abort.
// Optional: define UART_ARB_TIMEOUT_EN to abort transfers stuck in ARM/BUSY for TIMEOUT cycles;
//           without it err is tied low and BUSY waits indefinitely.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    busy,
    output logic                    ser_start,
    output logic [DW-1:0]           ser_data,
    input  logic                    ser_busy,
    output logic                    err
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_check
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic            grant_ld;
    logic            abort;
    logic            arm_cnt;
    logic [DW-1:0]   req_bytes [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_bytes[i] = req_data[i*DW +: DW];
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;
`endif

    always_comb begin
        state_nxt = state;
        grant_ld  = 1'b0;
        abort     = 1'b0;
        ack       = '0;
        case (state)
            // A serializer still busy from before (or after reset) blocks new grants.
            IDLE: begin
                if (pick_vld && !ser_busy) begin
                    state_nxt = START;
                    grant_ld  = 1'b1;
                end
            end
            START: state_nxt = ARM;
            // Give ser_busy two cycles to rise; a very short frame may already be over.
            ARM: begin
                if (ser_busy || arm_cnt) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!ser_busy) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack       = NREQ'(1) << grant_idx;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        if ((state == ARM || state == BUSY) && to_cnt == CW'(TIMEOUT - 1)) begin
            state_nxt = IDLE;
            abort     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            ser_data  <= '0;
            ser_start <= 1'b0;
            ptr       <= '0;
            arm_cnt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ser_start <= (state == START);
            arm_cnt   <= (state == ARM);
            if (grant_ld) begin
                grant_idx <= pick_idx;
                ser_data  <= req_bytes[pick_idx];
            end
            // The owner just served (or aborted) drops to lowest priority.
            if (state == DONE || abort) begin
                ptr <= IW'(rr_next(32'(grant_idx), NREQ));
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Counts cycles spent in ARM+BUSY; zero on every entry into ARM.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            err    <= abort;
            to_cnt <= (state == ARM || state == BUSY) ? to_cnt + CW'(1) : '0;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      ack;
    logic [1:0]           grant_idx;
    logic                 busy;
    logic                 ser_start;
    logic [DW-1:0]        ser_data;
    logic                 ser_busy;
    logic                 err;

    int n_cmp = 0;
    int n_bad = 0;

    // Serializer model controls
    int ser_dly = 1;
    int ser_len = 3;
    bit model_busy = 1'b0;
    bit ser_force = 1'b0;
    assign ser_busy = model_busy | ser_force;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant_idx (grant_idx),
        .busy      (busy),
        .ser_start (ser_start),
        .ser_data  (ser_data),
        .ser_busy  (ser_busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Serializer: busy rises ser_dly cycles after ser_start, stays high ser_len cycles.
    initial begin
        int dly_cnt;
        int len_cnt;
        dly_cnt = 0;
        len_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dly_cnt    = 0;
                len_cnt    = 0;
                model_busy = 1'b0;
            end else if (len_cnt > 0) begin
                len_cnt--;
                if (len_cnt == 0) model_busy = 1'b0;
            end else if (dly_cnt > 0) begin
                dly_cnt--;
                if (dly_cnt == 0) begin
                    model_busy = 1'b1;
                    len_cnt    = ser_len;
                end
            end else if (ser_start) begin
                dly_cnt = ser_dly;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ser_start !== 1'b1 && n < 20);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete transfer, started at a negedge while the arbiter is IDLE.
    task automatic do_txn(input logic [3:0] mask, input int exp_idx, input logic [7:0] exp_dat,
                          input int dly, input int len, input bit drop_mid, input string tag);
        int n;
        int m;
        ser_dly = dly;
        ser_len = len;
        req     = mask;
        wait_start(n);
        check({tag, "_start_lat"}, n, 2);
        check({tag, "_grant"}, grant_idx, exp_idx);
        check({tag, "_data"}, ser_data, exp_dat);
        check({tag, "_busy"}, busy, 1);
        m = 0;
        do begin
            @(negedge clk);
            m++;
            if (drop_mid && m == 3) begin
                req      = '0;
                req_data = $urandom;
            end
        end while (ack == '0 && m < 60);
        check({tag, "_ack_lat"}, m, dly + len + 1);
        check({tag, "_ack"}, ack, 32'(1) << exp_idx);
        check({tag, "_data_hold"}, ser_data, exp_dat);
        req = '0;
        @(negedge clk);
        check({tag, "_ack_pulse"}, ack, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    typedef struct {
        logic [3:0] req;
        int         idx;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        int m;
        int k;
        int win;
        int mptr;
        bit ack_seen;
        logic [3:0] mask;
        int cnt [4];
        logic [7:0] exp_seq [5];

        // Table from ptr=0 after reset, bytes 11/22/33/44 for requesters 0..3.
        tbl[0] = '{4'b0100, 2, 8'h33};
        tbl[1] = '{4'b1001, 3, 8'h44};
        tbl[2] = '{4'b1001, 0, 8'h11};
        tbl[3] = '{4'b1111, 1, 8'h22};
        tbl[4] = '{4'b0011, 0, 8'h11};
        tbl[5] = '{4'b0011, 1, 8'h22};
        tbl[6] = '{4'b1000, 3, 8'h44};
        tbl[7] = '{4'b0110, 1, 8'h22};
        tbl[8] = '{4'b1101, 2, 8'h33};
        tbl[9] = '{4'b0111, 0, 8'h11};
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
        exp_seq[3] = 8'h44; exp_seq[4] = 8'h11;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_start", ser_start, 0);
        check("rst_data", ser_data, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        // Single requester 2, 10-cycle frame
        req_data = 32'h00A5_0000;
        do_txn(4'b0100, 2, 8'hA5, 1, 10, 1'b0, "single");

        // Full load: strictly cyclic service
        pulse_reset();
        req_data = 32'h4433_2211;
        ser_dly = 1;
        ser_len = 3;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_start(n);
            check($sformatf("load%0d_lat", g), n, (g == 0) ? 2 : 3);
            check($sformatf("load%0d_data", g), ser_data, exp_seq[g]);
            m = 0;
            do begin
                @(negedge clk);
                m++;
            end while (ack == '0 && m < 60);
            check($sformatf("load%0d_ack", g), ack, 32'(1) << (g % 4));
            for (int i = 0; i < 4; i++) if (ack[i]) cnt[i]++;
            if (g == 3) begin
                for (int i = 0; i < 4; i++) check($sformatf("load_round_ack%0d", i), cnt[i], 1);
            end
        end
        req = '0;
        @(negedge clk);

        // Table-driven vectors incl. pointer wrap (ptr=3, req=1001)
        pulse_reset();
        req_data = 32'h4433_2211;
        for (int r = 0; r < 10; r++) begin
            do_txn(tbl[r].req, tbl[r].idx, tbl[r].dat, 1 + (r % 2), 2 + (r % 3), 1'b0,
                   $sformatf("vec%0d", r));
        end

        // Requester 1 drops req and data changes mid-transfer (ptr=1 now)
        req_data = 32'h4433_5C11;
        do_txn(4'b0010, 1, 8'h5C, 1, 6, 1'b1, "drop");

        // Serializer busy while IDLE holds off the grant (ptr=2 now)
        req_data  = 32'h4433_2211;
        ser_force = 1'b1;
        req       = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_start", i), ser_start, 0);
            check($sformatf("hold%0d_busy", i), busy, 0);
        end
        ser_force = 1'b0;
        do_txn(4'b0001, 0, 8'h11, 1, 3, 1'b0, "hold_release");

        // Reset during BUSY
        req_data = 32'h4477_2211;
        ser_dly  = 1;
        ser_len  = 10;
        req      = 4'b0100;
        wait_start(n);
        check("rstmid_lat", n, 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_start", ser_start, 0);
        check("rstmid_ack", ack, 0);
        check("rstmid_grant", grant_idx, 0);
        @(negedge clk);
        check("rstmid_ack2", ack, 0);
        reset = 1'b0;
        do_txn(4'b0100, 2, 8'h77, 1, 3, 1'b0, "rstmid_regrant");

        // Randomized transfers against the round-robin reference
        pulse_reset();
        mptr = 0;
        for (int r = 0; r < 40; r++) begin
            mask     = 4'($urandom_range(1, 15));
            req_data = $urandom;
            win = -1;
            for (int s = 0; s < NREQ; s++) begin
                if (win < 0 && mask[(mptr + s) % NREQ]) win = (mptr + s) % NREQ;
            end
            do_txn(mask, win, req_data[win*DW +: DW], $urandom_range(1, 2),
                   $urandom_range(3, 6), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
            mptr = (win + 1) % NREQ;
        end

`ifdef UART_ARB_TIMEOUT_EN
        // Serializer stuck busy: abort after 16 cycles in ARM/BUSY, next requester served
        pulse_reset();
        req_data = 32'h4433_2211;
        ser_dly  = 1;
        ser_len  = 2;
        req      = 4'b0011;
        wait_start(n);
        check("to_lat", n, 2);
        check("to_grant", grant_idx, 0);
        ser_force = 1'b1;
        k = 0;
        ack_seen = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (ack != '0) ack_seen = 1'b1;
        end while (err !== 1'b1 && k < 30);
        check("to_err_cycle", k, 16);
        check("to_no_ack", ack_seen, 0);
        check("to_idle", busy, 0);
        ser_force = 1'b0;
        do_txn(4'b0011, 1, 8'h22, 1, 2, 1'b0, "to_next");
        check("to_err_pulse", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
